uart_mem_loader: RTL and testbench



---
 rtl/uart_mem_loader_pkg.sv | 6 +
 rtl/uart_mem_loader.sv | 116 +++++++++++
 tb/tb_uart_mem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: shared frame-parser state encoding and constants
package uart_mem_loader_pkg;
    typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CSUM} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int CSUM_W = 8;
endpackage

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses sync/length/data/checksum frames from UART RX bytes
// and writes little-endian 16-bit words into memory.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int MAX_WORDS = 8192,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_valid,
    input  logic [7:0]        uart_data,
    output logic              uart_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
    state_t state, state_n;
    logic [15:0] len, len_n, len_full;
    logic [7:0] low, low_n;
    logic [CSUM_W-1:0] csum, csum_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0] wdata_n;
    logic [ADDR_W:0] count_n, count_inc;
    logic accept, ack_n, we_n, done_n, error_n;
    // A byte is never accepted while its ack is still showing, which paces the stream to one byte per two cycles.
    assign accept = uart_valid && !uart_ack;
    assign busy = state != SYNC;
    assign len_full = {uart_data, len[7:0]};
    assign count_inc = words_written + 1'b1;
    always_comb begin
        state_n = state;
        len_n = len;
        low_n = low;
        csum_n = csum;
        addr_n = mem_addr;
        wdata_n = mem_wdata;
        count_n = words_written;
        done_n = done;
        error_n = error;
        ack_n = accept;
        we_n = 1'b0;
        if (accept) begin
            case (state)
                SYNC: if (uart_data == SYNC_BYTE) begin
                    state_n = LEN_LO;
                    done_n = 1'b0;
                    error_n = 1'b0;
                    count_n = '0;
                    csum_n = '0;
                end
                LEN_LO: begin
                    len_n[7:0] = uart_data;
                    state_n = LEN_HI;
                end
                LEN_HI: begin
                    len_n = len_full;
                    error_n = len_full > MAX_LEN;
                    state_n = len_full > MAX_LEN ? SYNC : (len_full == 16'd0 ? CSUM : DAT_LO);
                end
                DAT_LO: begin
                    low_n = uart_data;
                    csum_n = csum ^ uart_data;
                    state_n = DAT_HI;
                end
                DAT_HI: begin
                    csum_n = csum ^ uart_data;
                    wdata_n = {uart_data, low};
                    addr_n = words_written[ADDR_W-1:0];
                    we_n = 1'b1;
                    count_n = count_inc;
                    state_n = 16'(count_inc) == len ? CSUM : DAT_LO;
                end
                CSUM: begin
                    done_n = uart_data == csum;
                    error_n = uart_data != csum;
                    state_n = SYNC;
                end
                default: state_n = SYNC;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
            len <= '0;
            low <= '0;
            csum <= '0;
            uart_ack <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            done <= 1'b0;
            error <= 1'b0;
            words_written <= '0;
        end else begin
            state <= state_n;
            len <= len_n;
            low <= low_n;
            csum <= csum_n;
            uart_ack <= ack_n;
            mem_we <= we_n;
            mem_addr <= addr_n;
            mem_wdata <= wdata_n;
            done <= done_n;
            error <= error_n;
            words_written <= count_n;
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: randomized frame uploads checked by write/status scoreboards
module tb_uart_mem_loader;
    localparam int AW = 4;
    localparam int MW = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic uart_ack, mem_we, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [AW:0] words_written;

    typedef struct packed {logic [AW-1:0] addr; logic [15:0] data;} wr_t;
    typedef struct packed {logic done; logic error; logic [AW:0] ww;} st_t;
    wr_t wr_q[$];
    st_t st_q[$];
    logic [15:0] fixed_q[$];
    int checks = 0, errors = 0, sent = 0, acks = 0;
    bit no_gap = 0;
    logic prev_busy = 1'b0, prev_ack = 1'b0;

    uart_mem_loader #(.ADDR_W(AW), .MAX_WORDS(MW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .uart_valid(uart_valid), .uart_data(uart_data),
        .uart_ack(uart_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboards whenever the DUT writes or finishes a frame.
    always @(negedge clk) begin
        wr_t e;
        st_t s;
        if (rst_n) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (uart_ack) acks++;
            if (uart_ack && prev_ack) chk("ack_width", 32'(prev_ack), 32'(1'b0));
            if (prev_busy && !busy) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_end: done %b error %b ww %0d", done, error, words_written);
                end else begin
                    s = st_q.pop_front();
                    chk("done", 32'(done), 32'(s.done));
                    chk("error", 32'(error), 32'(s.error));
                    chk("words_written", 32'(words_written), 32'(s.ww));
                end
            end
        end
        prev_busy = rst_n && busy;
        prev_ack = rst_n && uart_ack;
    end

    task automatic send_byte(input logic [7:0] b);
        int n, g, exp_n;
        g = no_gap ? 0 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        if (g > 0) begin
            uart_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
        end
        exp_n = uart_ack ? 2 : 1;
        uart_valid = 1'b1;
        uart_data = b;
        sent++;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!uart_ack && n < 20);
        if (!uart_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles, required within 2", n);
        end else chk("ack_latency", 32'(n), 32'(exp_n));
    endtask

    task automatic junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        send_byte(b == 8'hA5 ? 8'h00 : b);
    endtask

    task automatic frame(input logic [15:0] len, input bit bad);
        logic [7:0] cs, c;
        logic [15:0] w;
        send_byte(8'hA5);
        send_byte(len[7:0]);
        if (int'(len) > MW) begin
            st_q.push_back('{1'b0, 1'b1, '0});
            send_byte(len[15:8]);
            return;
        end
        send_byte(len[15:8]);
        cs = 8'h00;
        for (int i = 0; i < int'(len); i++) begin
            w = fixed_q.size() > 0 ? fixed_q.pop_front() : 16'($urandom);
            send_byte(w[7:0]);
            wr_q.push_back('{AW'(i), w});
            send_byte(w[15:8]);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        c = bad ? cs ^ 8'($urandom_range(1, 255)) : cs;
        st_q.push_back('{c == cs, c != cs, (AW + 1)'(len)});
        send_byte(c);
    endtask

    initial begin
        logic [15:0] w;
        int r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(uart_ack), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ww", 32'(words_written), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fixed_q = '{16'h1234, 16'h5678};
        frame(16'd2, 1'b0);
        fixed_q = '{16'h1234, 16'h5678};
        frame(16'd2, 1'b1);
        frame(16'd8193, 1'b0);
        send_byte(8'h00);
        send_byte(8'hFF);
        frame(16'd0, 1'b0);
        frame(16'(MW), 1'b0);
        frame(16'(MW + 1), 1'b0);
        frame(16'hFFFF, 1'b0);
        no_gap = 1;
        frame(16'd5, 1'b0);
        no_gap = 0;

        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        w = 16'hBEEF;
        send_byte(w[7:0]);
        wr_q.push_back('{AW'(0), w});
        send_byte(w[15:8]);
        uart_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ack", 32'(uart_ack), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_wdata", 32'(mem_wdata), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_error", 32'(error), 0);
        chk("mid_rst_ww", 32'(words_written), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame(16'd4, 1'b0);
        @(negedge clk);
        chk("post_rst_done", 32'(done), 1);

        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) junk_byte();
            r = $urandom_range(0, 9);
            frame(r < 8 ? 16'($urandom_range(0, 8)) : (r == 8 ? 16'(MW) : 16'($urandom_range(MW + 1, 65535))),
                  $urandom_range(0, 2) == 0);
        end

        uart_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("writes_pending", 32'(wr_q.size()), 0);
        chk("status_pending", 32'(st_q.size()), 0);
        chk("ack_count", 32'(acks), 32'(sent));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
